// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 convolution sequencer.
//   window_t    : 3x3 window of unsigned 8-bit pixels, element [row][col]
//   kernel_t    : 3x3 signed 8-bit kernel, element [row][col]
//   state_t     : sequencer states
//   MAC_W       : width of the external MAC sum
//   post_process: arithmetic shift, ReLU and saturation to 8 bits
package conv_pkg;

    localparam int unsigned MAC_W = 22;

    typedef logic [2:0][2:0][7:0]        window_t;
    typedef logic signed [2:0][2:0][7:0] kernel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LAST,
        ST_RESULT,
        ST_OUT,
        ST_DONE
    } state_t;

    // Shift is applied to the full signed sum; saturation looks at every bit
    // above bit 7 of the shifted value, so large sums never alias into range.
    function automatic logic [7:0] post_process(
        input logic signed [MAC_W-1:0] acc,
        input int unsigned             shift
    );
        logic signed [MAC_W-1:0] s;
        logic [7:0]              res;
        s = acc >>> shift;
        if (s[MAC_W-1]) begin
            res = 8'd0;
        end else if (|s[MAC_W-2:8]) begin
            res = 8'hFF;
        end else begin
            res = s[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/conv3x3_addr_gen.sv
// Window walker and feature RAM address generator.
// Holds the output row/col counters and the in-window tap counter (kept as
// separate tap row/col so no divide or modulo by 3 is needed).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : zero all counters (frame start)
//   fetch        : a tap read is issued this cycle; tap counter advances
//   advance      : output handshake; move to the next window
//   row, col     : current window origin
//   k            : current tap index 0..8 (row-major)
//   k_last       : current tap is tap 8
//   win_last     : current window is the final one of the frame
//   addr         : (row+k/3)*IMG_W + col + k%3 while fetching, else 0
module conv3x3_addr_gen #(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              fetch,
    input  logic              advance,
    output logic [7:0]        row,
    output logic [7:0]        col,
    output logic [3:0]        k,
    output logic              k_last,
    output logic              win_last,
    output logic [ADDR_W-1:0] addr
);

    logic [7:0]        row_q, row_d;
    logic [7:0]        col_q, col_d;
    logic [1:0]        kr_q, kr_d;
    logic [1:0]        kc_q, kc_d;
    logic [ADDR_W-1:0] lin_addr;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        kr_d  = kr_q;
        kc_d  = kc_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
            kr_d  = '0;
            kc_d  = '0;
        end else begin
            if (fetch) begin
                if (kc_q == 2'd2) begin
                    kc_d = '0;
                    kr_d = (kr_q == 2'd2) ? 2'd0 : kr_q + 2'd1;
                end else begin
                    kc_d = kc_q + 2'd1;
                end
            end
            if (advance) begin
                if (col_q == 8'(IMG_W - 3)) begin
                    col_d = '0;
                    row_d = row_q + 8'd1;
                end else begin
                    col_d = col_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            kr_q  <= '0;
            kc_q  <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            kr_q  <= kr_d;
            kc_q  <= kc_d;
        end
    end

    assign lin_addr = (ADDR_W'(row_q) + ADDR_W'(kr_q)) * ADDR_W'(IMG_W)
                    + ADDR_W'(col_q) + ADDR_W'(kc_q);

    assign addr     = fetch ? lin_addr : '0;
    assign row      = row_q;
    assign col      = col_q;
    assign k        = 4'(kr_q) * 4'd3 + 4'(kc_q);
    assign k_last   = (kr_q == 2'd2) && (kc_q == 2'd2);
    assign win_last = (row_q == 8'(IMG_H - 3)) && (col_q == 8'(IMG_W - 3));

endmodule

// File: rtl/conv3x3_sched.sv
// Sequencer for an external combinational 3x3 MAC.
// Loads a 9-tap signed kernel while idle, then for every valid 3x3 window of
// an IMG_H x IMG_W feature map: reads 9 pixels from single-port RAM, presents
// window + kernel to the MAC, post-processes the sum and emits one pixel on a
// valid/ready stream.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start / busy / done   : frame control (start pulse, busy level, done pulse)
//   kw_valid, kw_data     : kernel tap write, row-major taps 0..8
//   fm_rd_en/addr/data    : feature RAM read port, data one cycle after enable
//   mac_feature/kernel    : registered operands to the MAC
//   mac_result            : signed MAC sum
//   out_valid/ready/data  : output pixel stream
//   out_row/col/last      : window position and end-of-frame flag
module conv3x3_sched
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic                    kw_valid,
    input  logic [7:0]              kw_data,
    output logic                    fm_rd_en,
    output logic [ADDR_W-1:0]       fm_rd_addr,
    input  logic [7:0]              fm_rd_data,
    output window_t                 mac_feature,
    output kernel_t                 mac_kernel,
    input  logic signed [MAC_W-1:0] mac_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_data,
    output logic [7:0]              out_row,
    output logic [7:0]              out_col,
    output logic                    out_last
);

    state_t     state_q, state_d;
    kernel_t    kernel_q, kernel_d;
    window_t    window_q, window_d;
    logic [3:0] kptr_q, kptr_d;
    logic [7:0] out_data_q, out_data_d;
    logic [7:0] out_row_q, out_row_d;
    logic [7:0] out_col_q, out_col_d;
    logic       out_last_q, out_last_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       ag_clear;
    logic       ag_fetch;
    logic       ag_advance;
    logic [7:0] ag_row;
    logic [7:0] ag_col;
    logic [3:0] ag_k;
    logic       ag_k_last;
    logic       ag_win_last;

    logic       cap_en;
    logic [3:0] cap_slot;

    conv3x3_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (ag_clear),
        .fetch    (ag_fetch),
        .advance  (ag_advance),
        .row      (ag_row),
        .col      (ag_col),
        .k        (ag_k),
        .k_last   (ag_k_last),
        .win_last (ag_win_last),
        .addr     (fm_rd_addr)
    );

    assign ag_fetch = (state_q == ST_FETCH);

    always_comb begin
        state_d    = state_q;
        kernel_d   = kernel_q;
        kptr_d     = kptr_q;
        out_data_d = out_data_q;
        out_row_d  = out_row_q;
        out_col_d  = out_col_q;
        out_last_d = out_last_q;
        ag_clear   = 1'b0;
        ag_advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (kw_valid) begin
                    for (int unsigned r = 0; r < 3; r++) begin
                        for (int unsigned c = 0; c < 3; c++) begin
                            if (kptr_q == 4'(r * 3 + c)) begin
                                kernel_d[2'(r)][2'(c)] = kw_data;
                            end
                        end
                    end
                    kptr_d = (kptr_q == 4'd8) ? 4'd0 : kptr_q + 4'd1;
                end
                if (start) begin
                    kptr_d   = '0;
                    ag_clear = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (ag_k_last) begin
                    state_d = ST_LAST;
                end
            end
            ST_LAST: begin
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                out_data_d = post_process(mac_result, SHIFT);
                out_row_d  = ag_row;
                out_col_d  = ag_col;
                out_last_d = ag_win_last;
                state_d    = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    ag_advance = 1'b1;
                    state_d    = out_last_q ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Read data lags the request by one cycle: tap k's request lands in
        // slot k-1 during FETCH, and the final slot is filled in LAST.
        cap_en   = 1'b0;
        cap_slot = '0;
        if (state_q == ST_FETCH && ag_k != 4'd0) begin
            cap_en   = 1'b1;
            cap_slot = ag_k - 4'd1;
        end else if (state_q == ST_LAST) begin
            cap_en   = 1'b1;
            cap_slot = 4'd8;
        end

        window_d = window_q;
        if (cap_en) begin
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    if (cap_slot == 4'(r * 3 + c)) begin
                        window_d[2'(r)][2'(c)] = fm_rd_data;
                    end
                end
            end
        end

        // Status outputs are registered from the next state so they line up
        // exactly with the state they describe.
        out_valid_d = (state_d == ST_OUT);
        done_d      = (state_d == ST_DONE);
        busy_d      = (state_d == ST_FETCH) || (state_d == ST_LAST) ||
                      (state_d == ST_RESULT) || (state_d == ST_OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            kernel_q    <= '0;
            window_q    <= '0;
            kptr_q      <= '0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            kernel_q    <= kernel_d;
            window_q    <= window_d;
            kptr_q      <= kptr_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign fm_rd_en    = ag_fetch;
    assign mac_feature = window_q;
    assign mac_kernel  = kernel_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_row     = out_row_q;
    assign out_col     = out_col_q;
    assign out_last    = out_last_q;

endmodule

// File: tb/tb_conv3x3_sched.sv
module tb_conv3x3_sched;

    localparam int W    = 5;
    localparam int H    = 5;
    localparam int AW   = 6;
    localparam int NOUT = (H - 2) * (W - 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       kw_valid;
    logic [7:0] kw_data;
    logic       out_ready;

    // DUT with SHIFT=0
    logic                     busy0, done0, rd_en0, valid0, last0;
    logic [AW-1:0]            addr0;
    logic [7:0]               rd_data0, data0, row0, col0;
    logic [2:0][2:0][7:0]     feat0, kern0;
    logic signed [21:0]       res0;
    // DUT with SHIFT=13, driven in lockstep
    logic                     busy1, done1, rd_en1, valid1, last1;
    logic [AW-1:0]            addr1;
    logic [7:0]               rd_data1, data1, row1, col1;
    logic [2:0][2:0][7:0]     feat1, kern1;
    logic signed [21:0]       res1;

    conv3x3_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .done(done0),
        .kw_valid(kw_valid), .kw_data(kw_data),
        .fm_rd_en(rd_en0), .fm_rd_addr(addr0), .fm_rd_data(rd_data0),
        .mac_feature(feat0), .mac_kernel(kern0), .mac_result(res0),
        .out_valid(valid0), .out_ready(out_ready), .out_data(data0),
        .out_row(row0), .out_col(col0), .out_last(last0)
    );

    conv3x3_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .SHIFT(13)) u_dut13 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy1), .done(done1),
        .kw_valid(kw_valid), .kw_data(kw_data),
        .fm_rd_en(rd_en1), .fm_rd_addr(addr1), .fm_rd_data(rd_data1),
        .mac_feature(feat1), .mac_kernel(kern1), .mac_result(res1),
        .out_valid(valid1), .out_ready(out_ready), .out_data(data1),
        .out_row(row1), .out_col(col1), .out_last(last1)
    );

    // Feature RAM and MAC environment
    logic [7:0] mem [64];
    always @(posedge clk) begin
        if (rd_en0) rd_data0 <= mem[addr0];
        if (rd_en1) rd_data1 <= mem[addr1];
    end

    int acc0, acc1;
    always_comb begin
        acc0 = 0;
        acc1 = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc0 += int'($signed(kern0[i][j])) * int'(feat0[i][j]);
                acc1 += int'($signed(kern1[i][j])) * int'(feat1[i][j]);
            end
        end
    end
    assign res0 = 22'(acc0);
    assign res1 = 22'(acc1);

    // Reference model and scoreboard
    typedef struct {
        int row;
        int col;
        bit last;
        int d0;
        int d13;
    } exp_t;

    exp_t exp_q[$];
    int   addr_q[$];
    int   img[W*H];
    int   kern[9];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int post(input int acc, input int sh);
        int s;
        s = acc >>> sh;
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic push_expected();
        exp_t e;
        int   acc;
        for (int r = 0; r <= H - 3; r++) begin
            for (int c = 0; c <= W - 3; c++) begin
                acc = 0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        acc += kern[i*3+j] * img[(r+i)*W + c + j];
                        addr_q.push_back((r+i)*W + c + j);
                    end
                end
                e.row  = r;
                e.col  = c;
                e.last = (r == H - 3) && (c == W - 3);
                e.d0   = post(acc, 0);
                e.d13  = post(acc, 13);
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor
    int         cyc = 0, t_fetch = 0, rd_cnt = 0, hs_cnt = 0, done_cnt = 0;
    logic       pv = 1'b0, pr = 1'b0, prd = 1'b0, plast = 1'b0;
    logic [7:0] pdata = '0, prow = '0, pcol = '0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n) begin
            if (rd_en0) begin
                if (!prd) t_fetch = cyc;
                rd_cnt++;
                if (addr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_read: addr %0d with no read expected", addr0);
                end else begin
                    check("rd_addr", int'(addr0), addr_q.pop_front());
                end
            end
            if (valid0 && !pv) check("latency", cyc - t_fetch, 11);
            if (pv && !pr) begin
                check("hold_valid", int'(valid0), 1);
                check("hold_data", int'(data0), int'(pdata));
                check("hold_pos", int'({last0, row0, col0}), int'({plast, prow, pcol}));
            end
            if (valid0 && out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: data %0d at (%0d,%0d)", data0, row0, col0);
                end else begin
                    e = exp_q.pop_front();
                    check("data_shift0", int'(data0), e.d0);
                    check("data_shift13", int'(data1), e.d13);
                    check("valid13", int'(valid1), 1);
                    check("out_row", int'(row0), e.row);
                    check("out_col", int'(col0), e.col);
                    check("out_last", int'(last0), int'(e.last));
                end
            end
            if (done0) begin
                done_cnt++;
                check("busy_with_done", int'(busy0), 0);
                check("done13", int'(done1), 1);
            end
            pv    = valid0;
            pr    = out_ready;
            prd   = rd_en0;
            pdata = data0;
            prow  = row0;
            pcol  = col0;
            plast = last0;
        end else begin
            pv  = 1'b0;
            prd = 1'b0;
        end
    end

    // Downstream ready driver: 0 = always ready, 1 = random, 2 = stall output 3
    int ready_mode = 0;
    int hs_base    = 0;
    int stall_cnt  = 0;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (valid0 && (hs_cnt - hs_base) == 3 && stall_cnt < 20) begin
                        out_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: begin
                    out_ready = 1'b1;
                    stall_cnt = 0;
                end
            endcase
        end
    end

    // Stimulus
    int rd_base   = 0;
    int done_base = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_image();
        for (int a = 0; a < 64; a++) mem[a] = (a < W*H) ? 8'(img[a]) : 8'h00;
    endtask

    task automatic load_kernel();
        for (int i = 0; i < 9; i++) begin
            kw_valid = 1'b1;
            kw_data  = 8'(kern[i]);
            tick();
        end
        kw_valid = 1'b0;
    endtask

    task automatic start_frame();
        push_expected();
        rd_base   = rd_cnt;
        hs_base   = hs_cnt;
        done_base = done_cnt;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check("busy_after_start", int'(busy0), 1);
    endtask

    task automatic finish_frame();
        int n;
        n = 0;
        while (done_cnt == done_base && n < 4000) begin
            tick();
            n++;
        end
        if (done_cnt == done_base) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: no done after %0d cycles", n);
        end
        repeat (3) tick();
        check("done_pulses", done_cnt - done_base, 1);
        check("outputs", hs_cnt - hs_base, NOUT);
        check("reads", rd_cnt - rd_base, 9 * NOUT);
        check("queue_empty", exp_q.size(), 0);
        check("idle_busy", int'(busy0), 0);
        exp_q.delete();
        addr_q.delete();
    endtask

    task automatic run_frame(input bit load);
        load_image();
        if (load) load_kernel();
        start_frame();
        finish_frame();
    endtask

    task automatic rand_image();
        for (int a = 0; a < W*H; a++) img[a] = int'($urandom_range(0, 255));
    endtask

    task automatic rand_kernel();
        for (int i = 0; i < 9; i++) kern[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        kw_valid = 1'b0;
        kw_data  = '0;
        repeat (3) tick();
        check("rst_busy", int'(busy0), 0);
        check("rst_done", int'(done0), 0);
        check("rst_rd_en", int'(rd_en0), 0);
        check("rst_addr", int'(addr0), 0);
        check("rst_valid", int'(valid0), 0);
        check("rst_outs", int'({data0, row0, col0, last0}), 0);
        check("rst_kernel", int'(kern0 == '0), 1);
        rst_n = 1'b1;
        tick();

        // All ones
        for (int a = 0; a < W*H; a++) img[a] = 1;
        for (int i = 0; i < 9; i++) kern[i] = 1;
        run_frame(1'b1);

        // Pixel = address, centre tap only
        for (int a = 0; a < W*H; a++) img[a] = a;
        for (int i = 0; i < 9; i++) kern[i] = (i == 4) ? 1 : 0;
        run_frame(1'b1);

        // Saturation and large shift
        for (int a = 0; a < W*H; a++) img[a] = 255;
        for (int i = 0; i < 9; i++) kern[i] = 127;
        run_frame(1'b1);

        // ReLU
        for (int a = 0; a < W*H; a++) img[a] = 10;
        for (int i = 0; i < 9; i++) kern[i] = -1;
        run_frame(1'b1);

        // Backpressure on output 3
        rand_image();
        for (int i = 0; i < 9; i++) kern[i] = 1;
        ready_mode = 2;
        run_frame(1'b1);
        ready_mode = 0;
        tick();

        // kw_valid and start while busy are ignored; kernel survives
        rand_image();
        rand_kernel();
        load_image();
        load_kernel();
        start_frame();
        repeat (30) tick();
        kw_valid = 1'b1;
        kw_data  = 8'h55;
        start    = 1'b1;
        tick();
        kw_valid = 1'b0;
        start    = 1'b0;
        finish_frame();
        rand_image();
        run_frame(1'b0);

        // Random frames with random backpressure; first reloads twice to wrap tap pointer
        ready_mode = 1;
        for (int f = 0; f < 4; f++) begin
            rand_image();
            if (f == 0) begin
                for (int i = 0; i < 9; i++) kern[i] = 77;
                load_kernel();
            end
            rand_kernel();
            run_frame(1'b1);
        end
        ready_mode = 0;
        tick();

        // Reset during FETCH
        rand_image();
        rand_kernel();
        load_image();
        load_kernel();
        start_frame();
        repeat (4) tick();
        check("fetch_active", int'(rd_en0), 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy0), 0);
        check("arst_rd_en", int'(rd_en0), 0);
        check("arst_addr", int'(addr0), 0);
        check("arst_valid", int'(valid0), 0);
        check("arst_feature", int'(feat0 == '0), 1);
        check("arst_kernel", int'(kern0 == '0), 1);
        check("arst_outs", int'({data0, row0, col0, last0, done0}), 0);
        exp_q.delete();
        addr_q.delete();
        done_base = done_cnt;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("no_done_after_reset", done_cnt - done_base, 0);
        check("idle_after_reset", int'(busy0 | valid0 | rd_en0), 0);
        // Kernel was cleared by reset
        for (int i = 0; i < 9; i++) kern[i] = 0;
        rand_image();
        run_frame(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
